// File: rtl/rc5_stream_ctrl_if.sv
// Host-side bundle for rc5_stream_ctrl: key offer, input block stream, result stream.
// master = host side, slave = controller side.
interface rc5_stream_ctrl_if #(
   parameter int BLK_W = 64,
   parameter int KEY_W = 128
);
   logic [KEY_W-1:0] key_in;
   logic             key_valid;
   logic             key_ready;
   logic [BLK_W-1:0] s_data;
   logic             s_mode;
   logic             s_valid;
   logic             s_ready;
   logic [BLK_W-1:0] m_data;
   logic             m_mode;
   logic             m_valid;
   logic             m_ready;

   modport master (
      output key_in, key_valid, s_data, s_mode, s_valid, m_ready,
      input  key_ready, s_ready, m_data, m_mode, m_valid
   );

   modport slave (
      input  key_in, key_valid, s_data, s_mode, s_valid, m_ready,
      output key_ready, s_ready, m_data, m_mode, m_valid
   );
endinterface

// File: rtl/rc5_stream_ctrl.sv
// RC5 core front-end: key sequencing, in/out block FIFOs, one-in-flight issue, watchdog.
// Optional RC5_STREAM_STATS_EN adds blk_count/to_count statistics outputs.
module rc5_stream_ctrl #(
   parameter int BLK_W   = 64,
   parameter int KEY_W   = 128,
   parameter int IDEPTH  = 4,
   parameter int ODEPTH  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   rc5_stream_ctrl_if.slave host,
   output logic             core_flag,
   output logic [KEY_W-1:0] core_key,
   output logic             core_key_en,
   input  logic             core_key_ok,
   output logic [BLK_W-1:0] core_din,
   output logic             core_din_en,
   input  logic [BLK_W-1:0] core_dout,
   input  logic             core_dout_en,
   output logic             keyed,
   output logic             err_timeout
`ifdef RC5_STREAM_STATS_EN
   ,
   output logic [31:0]      blk_count,
   output logic [7:0]       to_count
`endif
);

   localparam int IAW = $clog2(IDEPTH);
   localparam int OAW = $clog2(ODEPTH);
   localparam int WW  = $clog2(TIMEOUT);

   localparam logic [1:0] NOKEY = 2'd0;
   localparam logic [1:0] KLOAD = 2'd1;
   localparam logic [1:0] IDLE  = 2'd2;
   localparam logic [1:0] WAIT  = 2'd3;

   localparam logic [IAW:0]  I_ONE = 1;
   localparam logic [OAW:0]  O_ONE = 1;
   localparam logic [WW-1:0] W_ONE = 1;
   localparam logic [WW-1:0] W_END = WW'(TIMEOUT - 1);

   logic [1:0]    state;
   logic [WW-1:0] wd;

   logic [BLK_W:0] imem [IDEPTH];
   logic [IAW:0]   iwp, irp;
   logic [BLK_W:0] omem [ODEPTH];
   logic [OAW:0]   owp, orp;

   logic           in_empty, in_full, in_push;
   logic           out_empty, out_full, out_push, out_pop;
   logic           key_hs, issue, busy, wd_fire;
   logic [BLK_W:0] ihead, ohead;

   assign in_empty  = (iwp == irp);
   assign in_full   = (iwp[IAW] != irp[IAW]) &&
                      (iwp[IAW-1:0] == irp[IAW-1:0]);
   assign out_empty = (owp == orp);
   assign out_full  = (owp[OAW] != orp[OAW]) &&
                      (owp[OAW-1:0] == orp[OAW-1:0]);

   assign ihead = imem[irp[IAW-1:0]];
   assign ohead = omem[orp[OAW-1:0]];

   assign host.s_ready   = !in_full;
   assign host.key_ready = (state == NOKEY) || (state == IDLE);
   assign host.m_valid   = !out_empty;
   assign host.m_data    = out_empty ? '0 : ohead[BLK_W-1:0];
   assign host.m_mode    = out_empty ? 1'b0 : ohead[BLK_W];

   assign in_push  = host.s_valid && !in_full;
   assign key_hs   = host.key_valid && host.key_ready;
   assign issue    = (state == IDLE) && !key_hs && !in_empty && !out_full;
   assign out_push = (state == WAIT) && core_dout_en;
   assign out_pop  = !out_empty && host.m_ready;
   assign busy     = (state == KLOAD) || (state == WAIT);
   // expiry only counts when the core did not answer in that same cycle
   assign wd_fire  = busy && (wd == W_END) &&
                     !((state == KLOAD) && core_key_ok) &&
                     !((state == WAIT) && core_dout_en);

   always_ff @(posedge clk) begin
      if (in_push) imem[iwp[IAW-1:0]] <= {host.s_mode, host.s_data};
      if (out_push) omem[owp[OAW-1:0]] <= {core_flag, core_dout};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iwp <= '0;
         irp <= '0;
         owp <= '0;
         orp <= '0;
      end else begin
         if (in_push) iwp <= iwp + I_ONE;
         if (issue) irp <= irp + I_ONE;
         if (out_push) owp <= owp + O_ONE;
         if (out_pop) orp <= orp + O_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= NOKEY;
         wd          <= '0;
         core_key    <= '0;
         core_key_en <= 1'b0;
         core_din    <= '0;
         core_din_en <= 1'b0;
         core_flag   <= 1'b0;
         keyed       <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         core_key_en <= 1'b0;
         core_din_en <= 1'b0;
         if (busy) wd <= wd + W_ONE;
         unique case (state)
            NOKEY: begin
               if (key_hs) begin
                  core_key    <= host.key_in;
                  core_key_en <= 1'b1;
                  wd          <= '0;
                  state       <= KLOAD;
               end
            end
            KLOAD: begin
               if (core_key_ok) begin
                  keyed <= 1'b1;
                  state <= IDLE;
               end else if (wd_fire) begin
                  err_timeout <= 1'b1;
                  keyed       <= 1'b0;
                  state       <= NOKEY;
               end
            end
            IDLE: begin
               if (key_hs) begin
                  core_key    <= host.key_in;
                  core_key_en <= 1'b1;
                  wd          <= '0;
                  state       <= KLOAD;
               end else if (issue) begin
                  core_din    <= ihead[BLK_W-1:0];
                  core_flag   <= ihead[BLK_W];
                  core_din_en <= 1'b1;
                  wd          <= '0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (core_dout_en) begin
                  state <= IDLE;
               end else if (wd_fire) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= NOKEY;
         endcase
      end
   end

`ifdef RC5_STREAM_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk_count <= '0;
         to_count  <= '0;
      end else begin
         if (out_push) blk_count <= blk_count + 32'd1;
         if (wd_fire && (to_count != 8'hFF)) to_count <= to_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rc5_stream_ctrl.sv
// Scoreboard bench for rc5_stream_ctrl: random blocks, behavioural core, queued expectations.
// A monitor pops the expected results whenever the controller hands out a block.
module tb_rc5_stream_ctrl;
   localparam int BW = 64;
   localparam int KW = 128;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rc5_stream_ctrl_if #(.BLK_W(BW), .KEY_W(KW)) hif ();

   logic          core_flag, core_key_en, core_key_ok;
   logic          core_din_en, core_dout_en, keyed, err_timeout;
   logic [KW-1:0] core_key;
   logic [BW-1:0] core_din, core_dout;
`ifdef RC5_STREAM_STATS_EN
   logic [31:0]   blk_count;
   logic [7:0]    to_count;
`endif

   rc5_stream_ctrl #(
      .BLK_W(BW), .KEY_W(KW), .IDEPTH(4), .ODEPTH(4), .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .host(hif),
      .core_flag(core_flag),
      .core_key(core_key),
      .core_key_en(core_key_en),
      .core_key_ok(core_key_ok),
      .core_din(core_din),
      .core_din_en(core_din_en),
      .core_dout(core_dout),
      .core_dout_en(core_dout_en),
      .keyed(keyed),
      .err_timeout(err_timeout)
`ifdef RC5_STREAM_STATS_EN
      ,
      .blk_count(blk_count),
      .to_count(to_count)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_ken = 0;
   int n_din = 0;
   int late_cnt = 0;
   int late_done = 0;
   bit chk_to = 1'b0;
   bit prev_din = 1'b0;
   bit done = 1'b0;
   logic [KW-1:0] mkey;
   logic [BW:0]   expq[$];
   logic [BW:0]   issq[$];
   logic [BW:0]   e_out, e_iss;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // the behavioural core transform shared by the core model and the expectations
   function automatic logic [BW-1:0] f(input logic [BW-1:0] d, input logic md,
                                       input logic [KW-1:0] k);
      return md ? (d ^ k[63:0]) : (d + k[127:64]);
   endfunction

   function automatic logic [BW-1:0] rnd();
      logic [BW-1:0] d;
      d = {$urandom, $urandom};
      if (d[7:0] == 8'hEE) d[7:0] = 8'h11;
      return d;
   endfunction

   always @(negedge clk) begin
      if (rst && hif.m_valid && hif.m_ready) begin
         if (expq.size() == 0) begin
            chk("unexpected_out", hif.m_valid, 1'b0);
         end else begin
            e_out = expq.pop_front();
            chk("out_block", {hif.m_mode, hif.m_data}, e_out);
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (core_key_en) n_ken++;
         if (core_din_en) begin
            n_din++;
            chk("issue_gap", prev_din, 1'b0);
            chk("keyed_at_issue", keyed, 1'b1);
            if (issq.size() == 0) begin
               chk("unexpected_issue", core_din_en, 1'b0);
            end else begin
               e_iss = issq.pop_front();
               chk("issue_block", {core_flag, core_din}, e_iss);
            end
         end
         prev_din = core_din_en;
      end else begin
         prev_din = 1'b0;
      end
   end

   initial begin
      logic [BW-1:0] r;
      int lat;
      core_key_ok  = 1'b0;
      core_dout_en = 1'b0;
      core_dout    = '0;
      forever begin
         @(negedge clk);
         if (!rst) continue;
         if (core_key_en) begin
            repeat (5) @(posedge clk);
            #1 core_key_ok = 1'b1;
            @(posedge clk);
            #1 core_key_ok = 1'b0;
         end else if (core_din_en) begin
            if (core_din[7:0] == 8'hEE) begin
               if (chk_to) begin
                  repeat (TO - 1) @(negedge clk);
                  chk("err_early", err_timeout, 1'b0);
                  @(negedge clk);
                  chk("err_set", err_timeout, 1'b1);
               end
            end else begin
               r   = f(core_din, core_flag, core_key);
               lat = $urandom_range(1, 4);
               repeat (lat) @(posedge clk);
               #1;
               core_dout    = r;
               core_dout_en = 1'b1;
               @(posedge clk);
               #1 core_dout_en = 1'b0;
            end
         end else if (late_cnt != late_done) begin
            late_done++;
            @(posedge clk);
            #1;
            core_dout    = 64'hDEAD_BEEF_0BAD_F00D;
            core_dout_en = 1'b1;
            @(posedge clk);
            #1 core_dout_en = 1'b0;
         end
      end
   end

   task automatic send(input logic [BW-1:0] d, input logic md, input bit hang);
      int t;
      hif.s_data  = d;
      hif.s_mode  = md;
      hif.s_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!hif.s_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("send_timeout", hif.s_ready, 1'b1);
      @(posedge clk);
      #1 hif.s_valid = 1'b0;
      if (!hang) expq.push_back({md, f(d, md, mkey)});
      issq.push_back({md, d});
   endtask

   task automatic load_key(input logic [KW-1:0] k);
      int t;
      int kb;
      kb = n_ken;
      mkey = k;
      hif.key_in = k;
      hif.key_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!hif.key_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1 hif.key_valid = 1'b0;
      @(negedge clk);
      chk("key_ready_kload", hif.key_ready, 1'b0);
      t = 0;
      while (!hif.key_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("keyed_after_ok", keyed, 1'b1);
      chk("key_en_pulses", n_ken - kb, 1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((expq.size() != 0 || issq.size() != 0) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("drain", expq.size() + issq.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset();
      chk("rst_key_ready", hif.key_ready, 1'b1);
      chk("rst_s_ready", hif.s_ready, 1'b1);
      chk("rst_m_valid", hif.m_valid, 1'b0);
      chk("rst_m_data", hif.m_data, 0);
      chk("rst_m_mode", hif.m_mode, 1'b0);
      chk("rst_key_en", core_key_en, 1'b0);
      chk("rst_din_en", core_din_en, 1'b0);
      chk("rst_flag", core_flag, 1'b0);
      chk("rst_core_key", core_key, 0);
      chk("rst_core_din", core_din, 0);
      chk("rst_keyed", keyed, 1'b0);
      chk("rst_err", err_timeout, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int base;
      int kb;
      int t;
      logic [3:0]    md4;
      logic [BW-1:0] d;
      logic          md;
      hif.key_in    = '0;
      hif.key_valid = 1'b0;
      hif.s_data    = '0;
      hif.s_mode    = 1'b0;
      hif.s_valid   = 1'b0;
      hif.m_ready   = 1'b1;
      mkey = '0;

      repeat (3) @(posedge clk);
      #1 check_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // blocks queue up before any key; only the key releases them
      md4  = 4'b1101;
      base = n_din;
      for (int i = 0; i < 4; i++) send(rnd(), md4[i], 1'b0);
      @(negedge clk);
      chk("s_ready_full", hif.s_ready, 1'b0);
      repeat (10) @(negedge clk);
      chk("no_issue_unkeyed", n_din - base, 0);
      @(posedge clk);
      #1 load_key('0);
      drain();
      chk("four_issues", n_din - base, 4);

      // output backpressure limits issues to the output FIFO depth
      hif.m_ready = 1'b0;
      base = n_din;
      for (int i = 0; i < 6; i++) send(rnd(), 1'($urandom_range(0, 1)), 1'b0);
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("bp_issues", n_din - base, 4);
      @(posedge clk);
      #1 hif.m_ready = 1'b1;
      @(posedge clk);
      #1 hif.m_ready = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("bp_one_more", n_din - base, 5);
      @(posedge clk);
      #1 hif.m_ready = 1'b1;
      drain();
      chk("bp_all", n_din - base, 6);

      // a key offered alongside a pending block wins
      base = n_din;
      kb   = n_ken;
      mkey = {$urandom, $urandom, $urandom, $urandom};
      d    = rnd();
      md   = 1'($urandom_range(0, 1));
      hif.s_data  = d;
      hif.s_mode  = md;
      hif.s_valid = 1'b1;
      expq.push_back({md, f(d, md, mkey)});
      issq.push_back({md, d});
      @(posedge clk);
      #1;
      hif.s_valid   = 1'b0;
      hif.key_in    = mkey;
      hif.key_valid = 1'b1;
      @(posedge clk);
      #1 hif.key_valid = 1'b0;
      t = 0;
      @(negedge clk);
      while (!core_key_ok && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("prio_no_issue", n_din - base, 0);
      chk("prio_key_en", n_ken - kb, 1);
      drain();
      chk("prio_issue", n_din - base, 1);

      // a silent core trips the watchdog; the next block still goes out
      chk_to = 1'b1;
      base   = n_din;
      d      = rnd();
      send({d[63:8], 8'hEE}, 1'b1, 1'b1);
      send(rnd(), 1'b0, 1'b0);
      drain();
      chk_to = 1'b0;
      chk("to_issues", n_din - base, 2);
      chk("to_sticky", err_timeout, 1'b1);
      late_cnt++;
      repeat (6) begin
         @(negedge clk);
         chk("late_ignored", hif.m_valid, 1'b0);
      end

      // random traffic with random output backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               d = rnd();
               if ($urandom_range(0, 7) == 0) send({d[63:8], 8'hEE}, 1'b1, 1'b1);
               else send(d, 1'($urandom_range(0, 1)), 1'b0);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 hif.m_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      hif.m_ready = 1'b1;
      drain();

      // reset while a block is in flight and two more are queued
      send({d[63:8], 8'hEE}, 1'b0, 1'b1);
      send(rnd(), 1'b1, 1'b0);
      send(rnd(), 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 check_reset();
      expq.delete();
      issq.delete();
      base = n_din;
      @(negedge clk);
      rst = 1'b1;
      late_cnt++;
      repeat (8) @(negedge clk);
      chk("post_rst_m_valid", hif.m_valid, 1'b0);
      @(posedge clk);
      #1 load_key({$urandom, $urandom, $urandom, $urandom});
      repeat (20) @(negedge clk);
      chk("post_rst_no_issue", n_din - base, 0);
      chk("post_rst_empty", hif.m_valid, 1'b0);
      @(posedge clk);
      #1 send(rnd(), 1'b1, 1'b0);
      drain();
      chk("post_rst_issue", n_din - base, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rc5_stream_ctrl.md
# rc5_stream_ctrl

Parametrised front-end controller for the RC5 cipher core. It buffers host blocks in an input FIFO with a per-block encrypt/decrypt mode, sequences key loading, and issues one block at a time to the core. It collects results into an output FIFO with valid/ready backpressure and supervises the core with a watchdog. It sits between the host bus and the RC5 core inside the top-level wrapper, replacing direct host drive of the core's enable strobes.

## Interface
- BLK_W, 64, block width in bits (core din/dout width)
- KEY_W, 128, key width in bits
- IDEPTH, 4, input FIFO depth in blocks (power of 2, ≥2)
- ODEPTH, 4, output FIFO depth in blocks (power of 2, ≥2)
- TIMEOUT, 1024, watchdog limit in cycles for one core operation (≥4)

- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous active-low reset
- key_in  in  KEY_W  host key
- key_valid  in  1  key offered
- key_ready  out  1  key accepted when key_valid & key_ready
- s_data  in  BLK_W  input block
- s_mode  in  1  block mode: 1 = encrypt, 0 = decrypt
- s_valid  in  1  block offered
- s_ready  out  1  input FIFO not full
- m_data  out  BLK_W  result block
- m_mode  out  1  mode the result was produced with
- m_valid  out  1  output FIFO not empty
- m_ready  in  1  host consumes result
- core_flag  out  1  mode to core
- core_key  out  KEY_W  key to core
- core_key_en  out  1  one-cycle key load strobe
- core_key_ok  in  1  core key schedule complete
- core_din  out  BLK_W  block to core
- core_din_en  out  1  one-cycle block strobe
- core_dout  in  BLK_W  core result
- core_dout_en  in  1  core result strobe
- keyed  out  1  a valid key is loaded
- err_timeout  out  1  sticky watchdog flag; cleared only by rst

## Operation
- FSM states: NOKEY, KLOAD, IDLE, WAIT.
- NOKEY: key_ready = 1. On handshake, register key_in into core_key, pulse core_key_en, and go to KLOAD. Blocks are buffered but not issued.
- KLOAD: key_ready = 0. When core_key_ok = 1, set keyed and go to IDLE. Watchdog expiry sets err_timeout, clears keyed, and returns to NOKEY.
- IDLE: key_ready = 1.
  - A key handshake has priority over a block issue in the same cycle: load the key and go to KLOAD.
  - Otherwise, if the input FIFO is non-empty and the output FIFO count is below ODEPTH, issue the head block: drive core_din and core_flag from the head, pulse core_din_en, pop, latch the mode, and go to WAIT.
- WAIT: key_ready = 0. On core_dout_en, push {latched mode, core_dout} into the output FIFO and go to IDLE. Watchdog expiry sets err_timeout, discards the block, and goes to IDLE; a later core_dout_en is ignored.
- The output FIFO never overflows: space is reserved before issue, with at most one block in flight.
- core_dout_en outside WAIT is ignored.
- core_key and core_flag hold their last values between strobes.
- The input FIFO accepts a push only when not full. Push and pop in the same cycle are allowed when it is non-full and non-empty.
- The output FIFO allows push and pop in the same cycle at any count, including full.
- FIFO pointers are log2(depth)+1 bits wide and wrap naturally. full = MSBs differ and LSBs equal.
- The watchdog counter clears on entry to KLOAD/WAIT and increments each cycle in those states. Expiry occurs when it reaches TIMEOUT-1.

## Timing
- Reset values:
  - state NOKEY; key_ready 1; s_ready 1; m_valid 0; m_data 0; m_mode 0.
  - core_key_en 0; core_din_en 0; core_flag 0; core_key 0; core_din 0.
  - keyed 0; err_timeout 0; FIFOs empty.
- s_ready, m_valid, key_ready: combinational from registered state/counts only.
- core_key_en and core_din_en are registered one-cycle pulses, asserted the cycle after the decision edge.
- Issue latency: a block pushed at edge N into an empty FIFO in IDLE gives core_din_en high during cycle N+1.
- Result latency: core_dout_en sampled at edge R gives m_valid high from R (after edge) with m_data = core_dout.
- Back-to-back issue: at least one IDLE cycle separates consecutive core_din_en pulses.
- Reset mid-operation discards FIFOs, the in-flight block and the key. A core result arriving after reset is ignored.

## Configuration
- RC5_STREAM_STATS_EN defined:
  - Adds output blk_count [31:0], reset 0, incremented on each output FIFO push; wraps at 2^32-1 → 0.
  - Adds output to_count [7:0], counting watchdog expiries and saturating at 255.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then key 0x0 load with core_key_ok at +5 → one core_key_en pulse; keyed=1 after core_key_ok; key_ready=0 during KLOAD.
- Push 4 blocks (modes 1,0,1,1) before the key, then load the key → four core_din_en pulses in order, each with the matching core_flag. m_data/m_mode arrive in order; s_ready=0 after the 4th push with IDEPTH=4.
- Hold m_ready=0 with ODEPTH=4 and 6 queued blocks → exactly 4 issues, then no core_din_en. Raising m_ready for one cycle → exactly one further issue.
- key_valid and non-empty FIFO together in IDLE → key loads first; block issues only after core_key_ok.
- Core never asserts dout_en with TIMEOUT=16 → err_timeout=1 16 cycles after core_din_en, block dropped, next block issued. A late dout_en is ignored, with no m_valid.
- Assert rst low while in WAIT with 2 blocks queued → all outputs return to reset values asynchronously; keyed=0; queued blocks are gone.
